// File: rtl/cb_config_loader.sv
// cb_config_loader: assembles config words in a shadow register and commits them to c atomically
module cb_config_loader #(
    parameter int CONF_WIDTH = 88,
    parameter int WORD_W     = 16,
    parameter int NWORDS     = (CONF_WIDTH + WORD_W - 1) / WORD_W,
    parameter int CNT_W      = $clog2(NWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_W-1:0]     cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  c_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
    state_t state, state_d;
    logic [CNT_W-1:0] count;
    logic [CONF_WIDTH-1:0] shadow;
    logic [NWORDS*WORD_W-1:0] merged;
    logic accept, last, pad_bad;
    assign accept  = cfg_valid & cfg_ready;
    assign last    = count == CNT_W'(NWORDS - 1);
    assign pad_bad = |(merged >> CONF_WIDTH);
    // Shadow with the incoming word dropped into its slot; anything above CONF_WIDTH is padding
    always_comb begin
        merged = (NWORDS*WORD_W)'(shadow);
        for (int i = 0; i < NWORDS; i++)
            if (count == CNT_W'(i)) merged[i*WORD_W +: WORD_W] = cfg_data;
    end
    // Next state and handshake outputs; abort beats both acceptance and commit
    always_comb begin
        state_d   = state;
        cfg_ready = state == LOAD;
        busy      = state != IDLE;
        if (state == IDLE)
            state_d = (start && !abort) ? LOAD : IDLE;
        else if (abort || state == COMMIT)
            state_d = IDLE;
        else if (accept && last)
            state_d = pad_bad ? IDLE : COMMIT;
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    // Datapath: shadow fill, padding error, single-cycle commit to c
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            shadow  <= '0;
            c       <= '0;
            c_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start && !abort) begin
                count  <= '0;
                shadow <= '0;
                err    <= 1'b0;
            end
            if (state == LOAD && !abort && accept) begin
                shadow <= merged[CONF_WIDTH-1:0];
                count  <= count + 1'b1;
                if (last && pad_bad) err <= 1'b1;
            end
            if (state == COMMIT && !abort) begin
                c       <= shadow;
                c_valid <= 1'b1;
                done    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cb_config_loader.sv
// tb_cb_config_loader: randomized transaction-level check of the config loader against a packing model
module tb_cb_config_loader;
    localparam int CW = 88;
    localparam int WW = 16;
    localparam int NW = 6;
    logic clk = 0, rst = 1, start = 0, abort = 0, cfg_valid = 0;
    logic [WW-1:0] cfg_data = '0;
    logic cfg_ready, c_valid, busy, done, err;
    logic [CW-1:0] c;
    logic [WW-1:0] words [NW];
    logic [CW-1:0] ref_c = '0;
    logic ref_cv = 0, ref_err = 0;
    int checks = 0, errors = 0, pulses = 0;

    cb_config_loader #(.CONF_WIDTH(CW), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .c(c), .c_valid(c_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) pulses++;
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_c"}, 96'(c), 96'(ref_c));
        check({tag, "_cv"}, 96'(c_valid), 96'(ref_cv));
        check({tag, "_err"}, 96'(err), 96'(ref_err));
        check({tag, "_busy"}, 96'(busy), 96'(0));
    endtask

    task automatic run_load(input int abort_at, input int max_gap, input bit hold_start);
        logic [95:0] expect_c;
        int p0;
        expect_c = '0;
        p0 = pulses;
        start = 1;
        tick();
        start = hold_start;
        check("busy_load", 96'(busy), 96'(1));
        for (int k = 0; k < NW; k++) begin
            if (abort_at == k) begin
                abort = 1;
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_data = words[k];
                tick();
                abort = 0;
                cfg_valid = 0;
                start = 0;
                ref_err = 0;
                check_hold("abort_load");
                check("abort_load_done", 96'(pulses), 96'(p0));
                return;
            end
            repeat ($urandom_range(0, max_gap)) begin
                cfg_valid = 0;
                cfg_data = WW'($urandom);
                tick();
            end
            cfg_valid = 1;
            cfg_data = words[k];
            check("ready", 96'(cfg_ready), 96'(1));
            tick();
            expect_c = expect_c | (96'(words[k]) << (WW * k));
        end
        cfg_valid = 0;
        cfg_data = WW'($urandom);
        check("ready_after_last", 96'(cfg_ready), 96'(0));
        if (words[NW-1][WW-1:WW-(NW*WW-CW)] != 0) begin
            start = 0;
            ref_err = 1;
            check_hold("pad_err");
            tick();
            check("pad_err_done", 96'(pulses), 96'(p0));
            check("pad_err_c_later", 96'(c), 96'(ref_c));
            return;
        end
        check("commit_busy", 96'(busy), 96'(1));
        check("commit_c_old", 96'(c), 96'(ref_c));
        check("commit_done_low", 96'(done), 96'(0));
        if (abort_at == NW) begin
            abort = 1;
            tick();
            abort = 0;
            start = 0;
            ref_err = 0;
            check_hold("abort_commit");
            check("abort_commit_done", 96'(pulses), 96'(p0));
            return;
        end
        tick();
        ref_c = expect_c[CW-1:0];
        ref_cv = 1;
        ref_err = 0;
        check("done_high", 96'(done), 96'(1));
        check_hold("commit");
        start = 0;
        tick();
        check("done_low", 96'(done), 96'(0));
        check("done_once", 96'(pulses), 96'(p0 + 1));
    endtask

    task automatic rand_words(input bit pad_ok);
        for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
        if (pad_ok) words[NW-1][WW-1:WW-(NW*WW-CW)] = '0;
        else words[NW-1][WW-1] = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_c", 96'(c), 96'(0));
        check("rst_cv", 96'(c_valid), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_err", 96'(err), 96'(0));
        check("rst_ready", 96'(cfg_ready), 96'(0));
        rst = 0;
        tick();
        for (int k = 0; k < NW; k++) words[k] = WW'(k + 1);
        run_load(-1, 0, 0);
        check("basic_c", 96'(c), 96'(88'h000600050004000300020001));
        rand_words(1);
        words[NW-1] = 16'hFF06;
        run_load(-1, 3, 0);
        rand_words(1);
        run_load(3, 2, 0);
        for (int k = 0; k < NW; k++) words[k] = 16'hAAAA;
        words[NW-1] = 16'h00AA;
        run_load(-1, 1, 0);
        check("abort_then_load_c", 96'(c), 96'({8'hAA, {5{16'hAAAA}}}));
        rand_words(1);
        run_load(NW, 1, 0);
        abort = 1;
        start = 1;
        tick();
        abort = 0;
        start = 0;
        check("idle_abort_busy", 96'(busy), 96'(0));
        check("idle_abort_ready", 96'(cfg_ready), 96'(0));
        start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 4; k++) begin
            cfg_valid = 1;
            cfg_data = WW'($urandom);
            tick();
        end
        cfg_valid = 0;
        #2 rst = 1;
        #1;
        check("arst_c", 96'(c), 96'(0));
        check("arst_cv", 96'(c_valid), 96'(0));
        check("arst_busy", 96'(busy), 96'(0));
        check("arst_ready", 96'(cfg_ready), 96'(0));
        @(negedge clk);
        rst = 0;
        ref_c = '0;
        ref_cv = 0;
        ref_err = 0;
        tick();
        rand_words(1);
        run_load(-1, 0, 1);
        rand_words(1);
        run_load(-1, 0, 1);
        for (int i = 0; i < 30; i++) begin
            rand_words($urandom_range(0, 3) != 0);
            run_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NW)) : -1,
                     3, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
